// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states and
// datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JUMP   = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_TRAP     = 4'd14
  } state_t;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUREG  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALUOUT  = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [2:0] IMM_I       = 3'b000;
  localparam logic [2:0] IMM_S       = 3'b001;
  localparam logic [2:0] IMM_B       = 3'b010;
  localparam logic [2:0] IMM_J       = 3'b011;
  localparam logic [2:0] IMM_U       = 3'b100;
  localparam logic [2:0] IMM_SHAMT   = 3'b101;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  localparam logic [6:0] F7_BASE     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;

  // Shift-immediate forms (SLLI/SRLI/SRAI) carry shamt instead of a full I-imm
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/mc_op_classify.sv
// DECODE successor selection from op_code/funct7.
// MC_ILLEGAL_TRAP_EN routes unknown opcodes and bad R-type funct7 to TRAP.
module mc_op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op_code,
  input  logic [6:0] funct7,
  output state_t     next_state
);

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t REJECT_STATE = ST_TRAP;
`else
  localparam state_t REJECT_STATE = ST_FETCH;
`endif

  logic w_f7_ok;

  assign w_f7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  always_comb begin
    next_state = REJECT_STATE;
    case (op_code)
      OP_LOAD,
      OP_STORE:  next_state = ST_MEMADR;
      OP_R_TYPE: next_state = w_f7_ok ? ST_EXEC_R : REJECT_STATE;
      OP_I_TYPE: next_state = ST_EXEC_I;
      OP_BRANCH: next_state = ST_BRANCH;
      OP_JUMP:   next_state = ST_JAL;
      OP_JALR:   next_state = ST_JALR;
      OP_LUI:    next_state = ST_LUI;
      OP_AUIPC:  next_state = ST_AUIPC;
      default:   next_state = REJECT_STATE;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32 control FSM with memory wait-timeout trap.
// Optional MC_ILLEGAL_TRAP_EN adds the sticky illegal_instr output.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] mem_size,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] state_o,
  output logic       mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

  state_t     r_state;
  logic [3:0] r_wait;
  logic       r_timeout;
  state_t     w_dec_next;
  logic       w_waiting;
  logic [3:0] w_wait_next;
  logic       w_wait_hit;

  mc_op_classify u_classify (
    .op_code    (op_code),
    .funct7     (funct7),
    .next_state (w_dec_next)
  );

  assign w_waiting   = mem_req & ~mem_ready;
  assign w_wait_next = r_wait + 4'd1;
  assign w_wait_hit  = w_waiting && (w_wait_next >= WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Any cycle that is not a stalled memory access restarts the count
      r_wait <= (w_waiting && !w_wait_hit) ? w_wait_next : '0;
      if (w_wait_hit) begin
        r_state   <= ST_TRAP;
        r_timeout <= 1'b1;
      end else begin
        case (r_state)
          ST_FETCH:    if (mem_ready) r_state <= ST_DECODE;
          ST_DECODE:   r_state <= w_dec_next;
          ST_MEMADR:   r_state <= (op_code == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
          ST_MEMREAD:  if (mem_ready) r_state <= ST_MEMWB;
          ST_MEMWRITE: if (mem_ready) r_state <= ST_FETCH;
          ST_EXEC_R,
          ST_EXEC_I,
          ST_AUIPC:    r_state <= ST_ALUWB;
          ST_TRAP:     r_state <= ST_TRAP;
          default:     r_state <= ST_FETCH;
        endcase
      end
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (r_state == ST_DECODE && w_dec_next == ST_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_instr = r_illegal;
`endif

  assign state_o     = r_state;
  assign mem_timeout = r_timeout;

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = '0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_I;
    result_src = RES_ALUREG;
    case (r_state)
      ST_FETCH: begin
        mem_req    = 1'b1;
        mem_size   = SIZE_WORD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op_code == OP_STORE) ? IMM_S : IMM_I;
      end
      ST_MEMREAD: begin
        mem_req  = 1'b1;
        adr_src  = 1'b1;
        mem_size = funct3;
      end
      ST_MEMWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        adr_src  = 1'b1;
        mem_size = funct3;
      end
      ST_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        imm_src   = is_shift_f3(funct3) ? IMM_SHAMT : IMM_I;
      end
      ST_ALUWB: begin
        result_src = RES_ALUREG;
        reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_BRANCH;
        result_src = RES_ALUREG;
        branch     = 1'b1;
      end
      ST_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUREG;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        imm_src    = IMM_J;
      end
      ST_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        result_src = RES_ALUREG;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
      end
      ST_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      ST_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        alu_op    = ALUOP_ADD;
      end
      default: ;
    endcase
  end

endmodule
